// File: rtl/memory_line_responder_pkg.sv
// Shared types and constants for the memory line responder.
// Types are sized for the default line/tag/index configuration.
package MemoryResponderTypes;

    localparam int DEFAULT_LINE_BYTE_NUM   = 8;
    localparam int DEFAULT_ADDR_WIDTH      = 32;
    localparam int DEFAULT_ID_WIDTH        = 2;
    localparam int DEFAULT_QUEUE_DEPTH     = 4;
    localparam int DEFAULT_MEM_INDEX_WIDTH = 10;
    localparam int DEFAULT_ACCESS_LATENCY  = 4;

    function automatic int lineOffsetWidth(input int lineBytes);
        return $clog2(lineBytes);
    endfunction

    localparam int LINE_OFFSET_WIDTH = lineOffsetWidth(DEFAULT_LINE_BYTE_NUM);

    typedef logic [DEFAULT_LINE_BYTE_NUM*8-1:0]  MemLineData;
    typedef logic [DEFAULT_ID_WIDTH-1:0]         MemReqId;
    typedef logic [DEFAULT_MEM_INDEX_WIDTH-1:0]  MemLineIndex;

    typedef struct packed {
        logic        isWrite;
        MemLineIndex index;
        MemLineData  data;
        MemReqId     id;
    } MemReqEntry;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MemResponderState;

endpackage

// File: rtl/memory_line_responder_queue.sv
// In-order request FIFO; the head stays visible until it is popped.
// Storage is not reset, only the pointers and occupancy count.
module mem_req_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_entries [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_entries[r_rdPtr];
    assign o_count  = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_entries[r_wrPtr] <= i_pushData;
        end
    end

endmodule

// File: rtl/memory_line_responder.sv
// Memory-side responder for cache line refills/writebacks: queues requests,
// waits a fixed latency, then accesses a line-granular array and responds in order.
module memory_line_responder
    import MemoryResponderTypes::*;
#(
    parameter int LINE_BYTE_NUM   = DEFAULT_LINE_BYTE_NUM,
    parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
    parameter int ID_WIDTH        = DEFAULT_ID_WIDTH,
    parameter int QUEUE_DEPTH     = DEFAULT_QUEUE_DEPTH,
    parameter int MEM_INDEX_WIDTH = DEFAULT_MEM_INDEX_WIDTH,
    parameter int ACCESS_LATENCY  = DEFAULT_ACCESS_LATENCY
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_reqValid,
    output logic                       o_reqReady,
    input  logic                       i_reqIsWrite,
    input  logic [ADDR_WIDTH-1:0]      i_reqAddr,
    input  logic [LINE_BYTE_NUM*8-1:0] i_reqData,
    input  logic [ID_WIDTH-1:0]        i_reqId,
    output logic                       o_rspValid,
    input  logic                       i_rspReady,
    output logic                       o_rspIsWrite,
    output logic [LINE_BYTE_NUM*8-1:0] o_rspData,
    output logic [ID_WIDTH-1:0]        o_rspId,
    output logic                       o_busy
);

    localparam int OFFSET_W = lineOffsetWidth(LINE_BYTE_NUM);
    localparam int DATA_W   = LINE_BYTE_NUM * 8;
    localparam int ENTRY_W  = 1 + MEM_INDEX_WIDTH + DATA_W + ID_WIDTH;
    localparam int QCNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int CNT_W    = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(ACCESS_LATENCY - 1);

    typedef struct packed {
        logic                       isWrite;
        logic [MEM_INDEX_WIDTH-1:0] index;
        logic [DATA_W-1:0]          data;
        logic [ID_WIDTH-1:0]        id;
    } LineReqEntry;

    MemResponderState    r_state;
    MemResponderState    w_nextState;
    logic [CNT_W-1:0]    r_counter;
    logic [CNT_W-1:0]    w_nextCounter;
    logic                w_access;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [QCNT_W-1:0]   w_count;
    LineReqEntry         w_pushEntry;
    LineReqEntry         w_headEntry;
    logic [ENTRY_W-1:0]  w_headBits;
    logic                r_rspIsWrite;
    logic [DATA_W-1:0]   r_rspData;
    logic [ID_WIDTH-1:0] r_rspId;
    logic [DATA_W-1:0]   r_memArray [2**MEM_INDEX_WIDTH];
    logic                w_unusedAddrBits;

    // Upper address bits alias onto the same lines; line-offset bits are don't-care.
    assign w_unusedAddrBits = ^{i_reqAddr[ADDR_WIDTH-1:OFFSET_W+MEM_INDEX_WIDTH],
                                i_reqAddr[OFFSET_W-1:0]};

    assign o_reqReady = !rst && !w_full;
    assign w_push     = i_reqValid && o_reqReady;
    assign w_pop      = (r_state == RESP) && i_rspReady;

    assign w_pushEntry.isWrite = i_reqIsWrite;
    assign w_pushEntry.index   = i_reqAddr[OFFSET_W +: MEM_INDEX_WIDTH];
    assign w_pushEntry.data    = i_reqData;
    assign w_pushEntry.id      = i_reqId;
    assign w_headEntry         = LineReqEntry'(w_headBits);

    mem_req_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushEntry),
        .i_pop      (w_pop),
        .o_head     (w_headBits),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_comb begin
        w_nextState   = r_state;
        w_nextCounter = r_counter;
        w_access      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_nextState   = WAIT;
                    w_nextCounter = RELOAD;
                end
            end
            WAIT: begin
                if (r_counter == '0) begin
                    w_access    = 1'b1;
                    w_nextState = RESP;
                end else begin
                    w_nextCounter = r_counter - CNT_W'(1);
                end
            end
            RESP: begin
                // A same-cycle push counts as a remaining entry, avoiding a detour through IDLE.
                if (i_rspReady) begin
                    if ((w_count > QCNT_W'(1)) || w_push) begin
                        w_nextState   = WAIT;
                        w_nextCounter = RELOAD;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_counter    <= '0;
            r_rspIsWrite <= 1'b0;
            r_rspData    <= '0;
            r_rspId      <= '0;
        end else begin
            r_state   <= w_nextState;
            r_counter <= w_nextCounter;
            if (w_access) begin
                r_rspIsWrite <= w_headEntry.isWrite;
                r_rspData    <= w_headEntry.isWrite ? '0 : r_memArray[w_headEntry.index];
                r_rspId      <= w_headEntry.id;
            end
        end
    end

    // Writes commit only on the WAIT->RESP edge, so a reset discards pending writes.
    always_ff @(posedge clk) begin
        if (w_access && w_headEntry.isWrite) begin
            r_memArray[w_headEntry.index] <= w_headEntry.data;
        end
    end

    assign o_rspValid   = (r_state == RESP);
    assign o_rspIsWrite = r_rspIsWrite;
    assign o_rspData    = r_rspData;
    assign o_rspId      = r_rspId;
    assign o_busy       = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_memory_line_responder.sv
// Directed bench for memory_line_responder: vector table plus hand-written
// sequences for back-pressure, full queue, ordering and mid-operation reset.
module tb_memory_line_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqIsWrite = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [63:0] reqData = '0;
    logic [1:0]  reqId = '0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic        rspIsWrite;
    logic [63:0] rspData;
    logic [1:0]  rspId;
    logic        busy;

    int cycleCnt = 0;
    int cmpCount = 0;
    int errCount = 0;

    memory_line_responder dut (
        .clk          (clk),
        .rst          (rst),
        .i_reqValid   (reqValid),
        .o_reqReady   (reqReady),
        .i_reqIsWrite (reqIsWrite),
        .i_reqAddr    (reqAddr),
        .i_reqData    (reqData),
        .i_reqId      (reqId),
        .o_rspValid   (rspValid),
        .i_rspReady   (rspReady),
        .o_rspIsWrite (rspIsWrite),
        .o_rspData    (rspData),
        .o_rspId      (rspId),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  id;
        logic [63:0] expData;
    } Vec;

    Vec vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic isWr, input logic [31:0] addr, input logic [63:0] data,
                                 input logic [1:0] id, output int acceptCycle);
        int guard = 0;
        reqValid   = 1'b1;
        reqIsWrite = isWr;
        reqAddr    = addr;
        reqData    = data;
        reqId      = id;
        while (!reqReady && guard < 100) begin
            stepCycle();
            guard++;
        end
        if (!reqReady) begin
            checkOutput("acceptTimeout", 64'(reqReady), 64'd1);
            reqValid    = 1'b0;
            acceptCycle = -1;
            return;
        end
        stepCycle();
        acceptCycle = cycleCnt;
        reqValid    = 1'b0;
    endtask

    task automatic waitRsp(output int rspCycle);
        int guard = 0;
        while (!rspValid && guard < 100) begin
            stepCycle();
            guard++;
        end
        if (!rspValid) begin
            checkOutput("rspTimeout", 64'(rspValid), 64'd1);
            rspCycle = -1;
        end else begin
            rspCycle = cycleCnt;
        end
    endtask

    task automatic collectRsp(input string tag, input logic expW, input logic [63:0] expData,
                              input logic [1:0] expId, input int expCycle);
        int c;
        waitRsp(c);
        checkOutput({tag, ".isWrite"}, 64'(rspIsWrite), 64'(expW));
        checkOutput({tag, ".data"}, rspData, expData);
        checkOutput({tag, ".id"}, 64'(rspId), 64'(expId));
        checkOutput({tag, ".cycle"}, 64'(c), 64'(expCycle));
        rspReady = 1'b1;
        stepCycle();
    endtask

    initial begin
        int accA, accB, hCycle, seen;
        int acc[4];
        logic [63:0] aa;
        logic [63:0] top;
        aa  = 64'hAAAA_AAAA_AAAA_AAAA;
        top = 64'h0123_4567_89AB_CDEF;

        vecs[0] = '{1'b1, 32'h0000_0100, 64'h1122_3344_5566_7788, 2'd1, 64'h0};
        vecs[1] = '{1'b0, 32'h0000_0100, 64'h0,                   2'd2, 64'h1122_3344_5566_7788};
        vecs[2] = '{1'b1, 32'h0000_0104, aa,                      2'd3, 64'h0};
        vecs[3] = '{1'b0, 32'h0000_0100, 64'h0,                   2'd0, aa};
        vecs[4] = '{1'b0, 32'h0000_2100, 64'h0,                   2'd1, aa};
        vecs[5] = '{1'b1, 32'h0000_1FF8, top,                     2'd2, 64'h0};
        vecs[6] = '{1'b0, 32'h0000_3FF8, 64'h0,                   2'd3, top};
        vecs[7] = '{1'b0, 32'hFFFF_E107, 64'h0,                   2'd2, aa};

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("rst.rspValid", 64'(rspValid), 64'd0);
        checkOutput("rst.rspIsWrite", 64'(rspIsWrite), 64'd0);
        checkOutput("rst.rspData", rspData, 64'd0);
        checkOutput("rst.rspId", 64'(rspId), 64'd0);
        checkOutput("rst.busy", 64'(busy), 64'd0);
        checkOutput("rst.reqReady", 64'(reqReady), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst.reqReadyAfter", 64'(reqReady), 64'd1);
        stepCycle();

        // Write then read back-to-back, response latency and spacing
        rspReady = 1'b1;
        applyStimulus(1'b1, 32'h100, 64'h1122_3344_5566_7788, 2'd1, accA);
        applyStimulus(1'b0, 32'h100, 64'h0, 2'd2, accB);
        checkOutput("t1.busy", 64'(busy), 64'd1);
        collectRsp("t1.ack", 1'b1, 64'h0, 2'd1, accA + LAT + 1);
        collectRsp("t1.rd", 1'b0, 64'h1122_3344_5566_7788, 2'd2, accA + 2 * (LAT + 1));
        stepCycle();

        // Table vectors, one request in flight at a time
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].id, accA);
            collectRsp($sformatf("vec%0d", i), vecs[i].isWrite, vecs[i].expData, vecs[i].id, accA + LAT + 1);
        end
        stepCycle();

        // Full queue under back-pressure, then held response stability
        rspReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h100, 64'h0, 2'(i), acc[i]);
        end
        checkOutput("t2.fullReady", 64'(reqReady), 64'd0);
        reqValid   = 1'b1;
        reqIsWrite = 1'b0;
        reqAddr    = 32'h1FF8;
        reqId      = 2'd1;
        waitRsp(accB);
        checkOutput("t2.firstCycle", 64'(accB), 64'(acc[0] + LAT + 1));
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("t3.valid%0d", k), 64'(rspValid), 64'd1);
            checkOutput($sformatf("t3.data%0d", k), rspData, aa);
            checkOutput($sformatf("t3.id%0d", k), 64'(rspId), 64'd0);
            checkOutput($sformatf("t3.isWrite%0d", k), 64'(rspIsWrite), 64'd0);
            checkOutput($sformatf("t3.reqReady%0d", k), 64'(reqReady), 64'd0);
            stepCycle();
        end
        rspReady = 1'b1;
        stepCycle();
        hCycle = cycleCnt;
        checkOutput("t2.readyAfterPop", 64'(reqReady), 64'd1);
        stepCycle();
        checkOutput("t2.fifthAccepted", 64'(reqReady), 64'd0);
        reqValid = 1'b0;
        collectRsp("t2.r1", 1'b0, aa, 2'd1, hCycle + LAT);
        collectRsp("t2.r2", 1'b0, aa, 2'd2, hCycle + LAT + (LAT + 1));
        collectRsp("t2.r3", 1'b0, aa, 2'd3, hCycle + LAT + 2 * (LAT + 1));
        collectRsp("t2.r5", 1'b0, top, 2'd1, hCycle + LAT + 3 * (LAT + 1));
        stepCycle();

        // Four queued reads complete in order, evenly spaced
        rspReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h100, 64'h0, 2'(i), acc[i]);
        end
        for (int i = 0; i < 4; i++) begin
            collectRsp($sformatf("t6.r%0d", i), 1'b0, aa, 2'(i), acc[0] + (LAT + 1) * (i + 1));
        end
        stepCycle();

        // Reset while a write is waiting: no response, write discarded
        applyStimulus(1'b1, 32'h100, 64'h5555_5555_5555_5555, 2'd0, acc[0]);
        applyStimulus(1'b0, 32'h100, 64'h0, 2'd1, acc[1]);
        applyStimulus(1'b0, 32'h100, 64'h0, 2'd2, acc[2]);
        rst = 1'b1;
        #1;
        checkOutput("t5.rspValid", 64'(rspValid), 64'd0);
        checkOutput("t5.busy", 64'(busy), 64'd0);
        checkOutput("t5.reqReady", 64'(reqReady), 64'd0);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("t5.reqReadyAfter", 64'(reqReady), 64'd1);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            stepCycle();
            if (rspValid) seen++;
        end
        checkOutput("t5.noRsp", 64'(seen), 64'd0);
        applyStimulus(1'b0, 32'h100, 64'h0, 2'd3, accA);
        collectRsp("t5.rd", 1'b0, aa, 2'd3, accA + LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
